// File: rtl/fechadura_pkg.sv
// Shared types and defaults for the lock mode controller.
package fechadura_pkg;
  localparam int CNT_W   = 6;
  localparam int NDIG    = 20;
  localparam int BCD_DIG = 6;

  localparam logic [3:0]       EMPTY_DIGIT     = 4'hF;
  localparam logic [CNT_W-1:0] DEF_BIP_TIME    = 6'd5;
  localparam logic [CNT_W-1:0] DEF_TRANCA_TIME = 6'd5;
  localparam logic [15:0]      DEF_MASTER      = 16'h1234;

  typedef struct packed { logic [NDIG-1:0][3:0]    digits; } senhaPac_t;
  typedef struct packed { logic [BCD_DIG-1:0][3:0] digits; } bcdPac_t;

  typedef struct packed {
    logic             bip_status;
    logic [CNT_W-1:0] bip_time;
    logic [CNT_W-1:0] tranca_aut_time;
    senhaPac_t        senha_master;
    senhaPac_t        senha_1;
    senhaPac_t        senha_2;
    senhaPac_t        senha_3;
    senhaPac_t        senha_4;
  } setupPac_t;

  typedef enum logic [1:0] {ST_LOCKED, ST_UNLOCKED, ST_SETUP} state_t;

  // digits[0] holds the most significant nibble of DEF_MASTER
  function automatic setupPac_t def_cfg();
    setupPac_t c;
    c.bip_status          = 1'b1;
    c.bip_time            = DEF_BIP_TIME;
    c.tranca_aut_time     = DEF_TRANCA_TIME;
    c.senha_master.digits = '1;
    for (int i = 0; i < 4; i++) c.senha_master.digits[i] = DEF_MASTER[15-4*i -: 4];
    c.senha_1.digits = '1;
    c.senha_2.digits = '1;
    c.senha_3.digits = '1;
    c.senha_4.digits = '1;
    return c;
  endfunction

  function automatic setupPac_t sanitize(setupPac_t n, setupPac_t o);
    setupPac_t r;
    r = n;
    if (n.tranca_aut_time == '0) r.tranca_aut_time = DEF_TRANCA_TIME;
    if (n.bip_time == '0)        r.bip_time        = DEF_BIP_TIME;
    if (n.senha_master.digits[0] == EMPTY_DIGIT) r.senha_master = o.senha_master;
    return r;
  endfunction
endpackage

// File: rtl/setup_ctrl_if.sv
// Link between the setup module (master) and the mode controller (slave).
interface setup_ctrl_if;
  import fechadura_pkg::*;
  logic      setup_on;
  setupPac_t data_setup_new;
  logic      data_setup_ok;
  logic      setup_display_en;
  bcdPac_t   setup_bcd;

  modport master (output data_setup_new, data_setup_ok, setup_display_en, setup_bcd,
                  input  setup_on);
  modport slave  (input  data_setup_new, data_setup_ok, setup_display_en, setup_bcd,
                  output setup_on);
endinterface

// File: rtl/tranca_timer.sv
// Auto-lock down-counter and door-open buzzer counter.
module tranca_timer import fechadura_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             reload,
  input  logic             freeze,
  input  logic             clear,
  input  logic             door,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] bip_time,
  input  logic             bip_status,
  output logic             expire,
  output logic             bip
);
  logic [CNT_W-1:0] lock_cnt, bip_cnt, bip_nxt;

  assign expire = !freeze && !reload && tick && (lock_cnt == CNT_W'(1));

  always_comb begin
    bip_nxt = bip_cnt;
    if (clear || (!freeze && !door)) bip_nxt = '0;
    else if (!freeze && tick && (bip_cnt != '1)) bip_nxt = bip_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
      bip_cnt  <= '0;
      bip      <= 1'b0;
    end else begin
      if (reload) lock_cnt <= load_val;
      else if (!freeze && tick && (lock_cnt != '0)) lock_cnt <= lock_cnt - 1'b1;
      bip_cnt <= bip_nxt;
      // evaluated on the next count so bip rises on the tick that reaches bip_time
      bip <= !freeze && !clear && !expire && door && bip_status && (bip_nxt >= bip_time);
    end
  end
endmodule

// File: rtl/setup_ctrl.sv
// Lock mode controller: owns the active config, sequences setup, drives bolt/buzzer and display mux.
module setup_ctrl import fechadura_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_1s,
  input  logic         unlock_valid,
  input  logic         unlock_master,
  input  logic         lock_req,
  input  logic         setup_req,
  input  logic         porta_aberta,
  input  logic         op_display_en,
  input  bcdPac_t      op_bcd,
  setup_ctrl_if.slave  sif,
  output setupPac_t    cfg,
  output logic         tranca,
  output logic         bip,
  output logic         display_en,
  output bcdPac_t      bcd_out
);
  state_t           state;
  logic             master_flag, do_lock, do_setup, commit, expire, freeze, reload;
  setupPac_t        new_cfg;
  logic [CNT_W-1:0] load_val;

  assign do_lock  = (state == ST_UNLOCKED) && lock_req && !porta_aberta;
  assign do_setup = (state == ST_UNLOCKED) && !do_lock && setup_req && master_flag;
  assign commit   = (state == ST_SETUP) && sif.data_setup_ok;
  assign new_cfg  = sanitize(sif.data_setup_new, cfg);
  assign reload   = ((state == ST_LOCKED) && unlock_valid) ||
                    ((state == ST_UNLOCKED) && porta_aberta) || commit;
  assign load_val = commit ? new_cfg.tranca_aut_time : cfg.tranca_aut_time;
  // leaving UNLOCKED this edge also freezes, so bip drops with the state change
  assign freeze   = (state != ST_UNLOCKED) || do_lock || do_setup;

  tranca_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_1s),
    .reload     (reload),
    .freeze     (freeze),
    .clear      (state == ST_LOCKED),
    .door       (porta_aberta),
    .load_val   (load_val),
    .bip_time   (cfg.bip_time),
    .bip_status (cfg.bip_status),
    .expire     (expire),
    .bip        (bip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_LOCKED;
      tranca       <= 1'b1;
      sif.setup_on <= 1'b0;
      cfg          <= def_cfg();
      master_flag  <= 1'b0;
    end else begin
      case (state)
        ST_LOCKED: if (unlock_valid) begin
          state       <= ST_UNLOCKED;
          tranca      <= 1'b0;
          master_flag <= unlock_master;
        end
        ST_UNLOCKED: if (do_lock || expire) begin
          state  <= ST_LOCKED;
          tranca <= 1'b1;
        end else if (do_setup) begin
          state        <= ST_SETUP;
          sif.setup_on <= 1'b1;
        end
        ST_SETUP: if (commit) begin
          cfg          <= new_cfg;
          state        <= ST_UNLOCKED;
          sif.setup_on <= 1'b0;
        end
        default: begin
          state        <= ST_LOCKED;
          tranca       <= 1'b1;
          sif.setup_on <= 1'b0;
        end
      endcase
    end
  end

  assign display_en = (state == ST_SETUP) ? sif.setup_display_en : op_display_en;
  assign bcd_out    = (state == ST_SETUP) ? sif.setup_bcd        : op_bcd;
endmodule
